rv32_register_file: RTL and testbench



---
 rtl/rv32_register_file.sv | 40 ++++
 tb/tb_rv32_register_file.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rv32_register_file.sv
// RV32I integer register file: 32 x 32-bit, x0 reads as zero.
// Two combinational read ports, one synchronous write port, synchronous reset.
module rv32_register_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_file_wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic [DATA_W-1:0] rd_data_2
);

  logic [DATA_W-1:0] reg_file [0:NUM_REGS-1];

  // Reset wins over a coincident write; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        reg_file[i] <= '0;
      end
    end else if (reg_file_wr_en && (wr_addr != '0)) begin
      reg_file[wr_addr] <= data_in;
    end
  end

  // No write bypass; x0 forced to zero regardless of array contents.
  always_comb begin
    rd_data_1 = '0;
    rd_data_2 = '0;
    if (rd_addr_1 != '0) rd_data_1 = reg_file[rd_addr_1];
    if (rd_addr_2 != '0) rd_data_2 = reg_file[rd_addr_2];
  end

endmodule

// File: tb/tb_rv32_register_file.sv
// Bench for rv32_register_file: vector table, reset/x0 sequences and a
// model-driven random phase, all checked through an expectation queue.
module tb_rv32_register_file;

  logic        clk;
  logic        reset;
  logic        reg_file_wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] data_in;
  logic [4:0]  rd_addr_1;
  logic [4:0]  rd_addr_2;
  logic [31:0] rd_data_1;
  logic [31:0] rd_data_2;

  rv32_register_file dut (
    .clk            (clk),
    .reset          (reset),
    .reg_file_wr_en (reg_file_wr_en),
    .wr_addr        (wr_addr),
    .data_in        (data_in),
    .rd_addr_1      (rd_addr_1),
    .rd_addr_2      (rd_addr_2),
    .rd_data_1      (rd_data_1),
    .rd_data_2      (rd_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    int          tag;
  } exp_t;

  localparam int unsigned NVEC = 16;

  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  logic [31:0] model [32];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input int tag,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %08h expected %08h", name, tag, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare both read ports.
  task automatic sb_check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got %08h/%08h expected none",
               name, rd_data_1, rd_data_2);
    end else begin
      e = sb_q.pop_front();
      check({name, ".rd1"}, e.tag, rd_data_1, e.e1);
      check({name, ".rd2"}, e.tag, rd_data_2, e.e2);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    reg_file_wr_en = we;
    wr_addr        = wa;
    data_in        = wd;
    rd_addr_1      = ra1;
    rd_addr_2      = ra2;
  endtask

  initial begin
    // Expected values are the pre-edge reads; a vector's write lands on the
    // following rising edge and is visible to later vectors.
    vecs[0]  = '{1'b1, 5'd1,  32'h1,        5'd1,  5'd2,  32'h0,     32'h0};
    vecs[1]  = '{1'b1, 5'd2,  32'h2,        5'd1,  5'd2,  32'h1,     32'h0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd1,  5'd2,  32'h1,     32'h2};
    vecs[3]  = '{1'b1, 5'd3,  32'h3,        5'd3,  5'd4,  32'h0,     32'h0};
    vecs[4]  = '{1'b0, 5'd0,  32'h0,        5'd3,  5'd4,  32'h3,     32'h0};
    vecs[5]  = '{1'b1, 5'd4,  32'hF0F0,     5'd1,  5'd4,  32'h1,     32'h0};
    vecs[6]  = '{1'b1, 5'd5,  32'hF0F0,     5'd1,  5'd5,  32'h1,     32'h0};
    vecs[7]  = '{1'b1, 5'd6,  32'hF0,       5'd1,  5'd4,  32'h1,     32'hF0F0};
    vecs[8]  = '{1'b1, 5'd7,  32'hF0,       5'd1,  5'd6,  32'h1,     32'hF0};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd7,  32'hF0F0,  32'hF0};
    vecs[10] = '{1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,     32'h0};
    vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd1,  32'h0,     32'h1};
    vecs[12] = '{1'b0, 5'd2,  32'h5,        5'd2,  5'd2,  32'h2,     32'h2};
    vecs[13] = '{1'b0, 5'd0,  32'h0,        5'd2,  5'd31, 32'h2,     32'h0};
    vecs[14] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd31, 32'h0,     32'h0};
    vecs[15] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd30, 32'hFFFFFFFF, 32'h0};

    reset = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven directed vectors.
    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra1, vecs[i].ra2);
      sb_q.push_back('{vecs[i].e1, vecs[i].e2, i});
      #1 sb_check("vec");
    end

    // Reads follow an address change with no clock edge in between.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd6);
    sb_q.push_back('{32'hF0F0, 32'hF0, 100});
    #1 sb_check("comb");
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    sb_q.push_back('{32'h3, 32'h3, 101});
    #1 sb_check("comb");

    // Reset together with a write: write dropped, every entry cleared.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 5'd1, 32'hAAAA5555, 5'd1, 5'd2);
    sb_q.push_back('{32'h1, 32'h2, 200});
    #1 sb_check("rst_pre");
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      rd_addr_1 = 5'(a);
      rd_addr_2 = 5'(31 - a);
      sb_q.push_back('{32'h0, 32'h0, 300 + a});
      #1 sb_check("rst_clr");
    end

    // Random traffic against a reference model of the register array.
    for (int a = 0; a < 32; a++) model[a] = 32'h0;
    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [4:0]  wa, ra1, ra2;
      logic [31:0] wd;
      @(negedge clk);
      we  = 1'($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      ra1 = 5'($urandom_range(0, 31));
      ra2 = (n % 7 == 0) ? wa : 5'($urandom_range(0, 31));
      drive(we, wa, wd, ra1, ra2);
      sb_q.push_back('{model[ra1], model[ra2], 1000 + n});
      #1 sb_check("rand");
      if (we && wa != 5'd0) model[wa] = wd;
    end

    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL sb_drain: got %0d leftover expected 0", sb_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
